// File: rtl/rc4_msg_checker.sv
// Plaintext legality checker between one RC4 decrypt core and its key-search controller.
// Optional macro RC4_CHECK_EARLY_ABORT_EN: report the verdict on the first rejected byte.
module rc4_msg_checker #(
  parameter int          MSG_LEN = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [7:0]  CHAR_LO = 8'h61,
  parameter logic [7:0]  CHAR_HI = 8'h7A,
  parameter logic [7:0]  CHAR_SP = 8'h20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             restart,
  input  logic                             stop_all,
  input  logic                             in_valid,
  input  logic [ADDR_W-1:0]                in_addr,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  output logic                             finish_decrypt,
  output logic                             valid,
  output logic [ADDR_W-1:0]                bad_addr,
  output logic [$clog2(MSG_LEN+1)-1:0]     byte_count
);

  localparam int CNT_W = $clog2(MSG_LEN+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_LEN-1);

  typedef enum logic [1:0] {CHECK, DONE, HALT} state_t;

  state_t               state_q;
  logic                 finish_q;
  logic                 valid_q;
  logic                 bad_q;
  logic [ADDR_W-1:0]    bad_addr_q;
  logic [CNT_W-1:0]     count_q;

  logic accept;
  logic char_ok;
  logic order_ok;
  logic reject;
  logic last;

  assign accept   = in_valid && (state_q == CHECK);
  assign char_ok  = ((in_data >= CHAR_LO) && (in_data <= CHAR_HI)) || (in_data == CHAR_SP);
  // Address and count may differ in width; compare them zero-extended.
  assign order_ok = (32'(in_addr) == 32'(count_q));
  assign reject   = !(char_ok && order_ok);
  assign last     = (count_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CHECK;
      finish_q   <= 1'b0;
      valid_q    <= 1'b0;
      bad_q      <= 1'b0;
      bad_addr_q <= '0;
      count_q    <= '0;
    end else if (stop_all) begin
      state_q <= HALT;
    end else if (state_q != HALT) begin
      if (restart) begin
        state_q    <= CHECK;
        finish_q   <= 1'b0;
        valid_q    <= 1'b0;
        bad_q      <= 1'b0;
        bad_addr_q <= '0;
        count_q    <= '0;
      end else if (accept) begin
        count_q <= count_q + CNT_W'(1);
        if (reject && !bad_q) begin
          bad_q      <= 1'b1;
          bad_addr_q <= in_addr;
        end
`ifdef RC4_CHECK_EARLY_ABORT_EN
        if (reject || last) begin
`else
        if (last) begin
`endif
          state_q  <= DONE;
          finish_q <= 1'b1;
          valid_q  <= !(bad_q || reject);
        end
      end
    end
  end

  assign in_ready       = (state_q == CHECK);
  assign finish_decrypt = finish_q;
  assign valid          = valid_q;
  assign bad_addr       = bad_addr_q;
  assign byte_count     = count_q;

endmodule

// File: tb/tb_rc4_msg_checker.sv
// Self-checking bench for rc4_msg_checker: directed scenarios plus randomized traffic
// compared every cycle against a message-level model.
module tb_rc4_msg_checker;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = $clog2(MSG_LEN+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              restart = 1'b0;
  logic              stop_all = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              finish_decrypt;
  logic              valid;
  logic [ADDR_W-1:0] bad_addr;
  logic [CNT_W-1:0]  byte_count;

  int n_checks = 0;
  int n_pass   = 0;

  rc4_msg_checker dut (
    .clk            (clk),
    .rst            (rst),
    .restart        (restart),
    .stop_all       (stop_all),
    .in_valid       (in_valid),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .finish_decrypt (finish_decrypt),
    .valid          (valid),
    .bad_addr       (bad_addr),
    .byte_count     (byte_count)
  );

  always #5 clk = ~clk;

  // Message-level model: how many bytes were taken, where the first bad one was,
  // whether a verdict has been issued and whether the core was halted.
  int m_count     = 0;
  int m_first_bad = -1;
  bit m_done      = 0;
  bit m_halted    = 0;

  function automatic bit legal(input logic [7:0] d);
    return (d >= 8'h61 && d <= 8'h7A) || d == 8'h20;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0; m_first_bad = -1; m_done = 0; m_halted = 0;
    end else if (m_halted) begin
    end else if (stop_all) begin
      m_halted = 1;
    end else if (restart) begin
      m_count = 0; m_first_bad = -1; m_done = 0;
    end else if (!m_done && in_valid) begin
      bit rej;
      rej = !legal(in_data) || (int'(in_addr) != m_count);
      if (rej && m_first_bad < 0) m_first_bad = int'(in_addr);
      m_count++;
      if (m_count == MSG_LEN) m_done = 1;
`ifdef RC4_CHECK_EARLY_ABORT_EN
      if (rej) m_done = 1;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("in_ready",       int'(in_ready),       int'(!m_done && !m_halted));
    check("finish_decrypt", int'(finish_decrypt), int'(m_done));
    check("valid",          int'(valid),          int'(m_done && m_first_bad < 0));
    check("bad_addr",       int'(bad_addr),       (m_first_bad < 0) ? 0 : m_first_bad);
    check("byte_count",     int'(byte_count),     m_count);
  end

  task automatic drive(input bit v, input int a, input logic [7:0] d,
                       input bit rs, input bit st);
    @(posedge clk); #2;
    in_valid = v; in_addr = ADDR_W'(a); in_data = d; restart = rs; stop_all = st;
  endtask

  function automatic logic [7:0] good_char(input int i);
    return (i % 5 == 4) ? 8'h20 : 8'(8'h61 + (i % 26));
  endfunction

  task automatic idle();
    drive(0, 0, 8'h00, 0, 0);
  endtask

  task automatic pulse_restart();
    drive(0, 0, 8'h00, 1, 0);
    idle();
    #1;
    check("restart finish", int'(finish_decrypt), 0);
    check("restart count",  int'(byte_count),     0);
    check("restart ready",  int'(in_ready),       1);
  endtask

  // Stream n bytes; byte bad_i carries 'A' and address skip_at and above shift by one.
  task automatic stream(input int n, input int bad_i, input int skip_at);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (i >= skip_at) ? ((i + 1 > 31) ? 31 : i + 1) : i;
      drive(1, a, (i == bad_i) ? 8'h41 : good_char(i), 0, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    #3;
    check("reset ready",  int'(in_ready),       1);
    check("reset finish", int'(finish_decrypt), 0);
    check("reset count",  int'(byte_count),     0);
    #9 rst = 1'b1;

    // legal message
    stream(32, -1, 99);
    idle(); #1;
    check("legal finish", int'(finish_decrypt), 1);
    check("legal valid",  int'(valid),          1);
    check("legal count",  int'(byte_count),     32);
    check("legal ready",  int'(in_ready),       0);
    pulse_restart();

    // fresh legal stream after restart
    stream(32, -1, 99);
    idle(); #1;
    check("fresh valid", int'(valid), 1);
    pulse_restart();

    // illegal character at address 5
    stream(32, 5, 99);
    idle(); #1;
    check("badchar finish", int'(finish_decrypt), 1);
    check("badchar valid",  int'(valid),          0);
    check("badchar addr",   int'(bad_addr),       5);
`ifdef RC4_CHECK_EARLY_ABORT_EN
    check("badchar count",  int'(byte_count),     6);
`else
    check("badchar count",  int'(byte_count),     32);
`endif
    pulse_restart();

    // out-of-order: addresses 0,1,3,...
    stream(32, -1, 2);
    idle(); #1;
    check("order finish", int'(finish_decrypt), 1);
    check("order valid",  int'(valid),          0);
    check("order addr",   int'(bad_addr),       3);
`ifdef RC4_CHECK_EARLY_ABORT_EN
    check("order count",  int'(byte_count),     3);
`else
    check("order count",  int'(byte_count),     32);
`endif
    pulse_restart();

    // stop_all with restart at byte 10
    stream(10, -1, 99);
    drive(1, 10, good_char(10), 1, 1);
    idle(); #1;
    check("halt count",  int'(byte_count), 10);
    check("halt ready",  int'(in_ready),   0);
    drive(0, 0, 8'h00, 1, 0);
    idle(); idle(); #1;
    check("halt restart count", int'(byte_count), 10);
    check("halt restart ready", int'(in_ready),   0);
    @(posedge clk); #2 rst = 1'b0; #2 rst = 1'b1;

    // asynchronous reset in the middle of a message
    stream(20, -1, 99);
    @(posedge clk); #3;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst count",  int'(byte_count),     0);
    check("midrst ready",  int'(in_ready),       1);
    check("midrst finish", int'(finish_decrypt), 0);
    check("midrst valid",  int'(valid),          0);
    check("midrst bad",    int'(bad_addr),       0);
    #3 rst = 1'b1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (m_halted && ($urandom % 4 == 0)) begin
        rst = 1'b0; stop_all = 1'b0; restart = 1'b0;
        #1 rst = 1'b1;
      end else begin
        restart  = m_done ? ($urandom % 6 == 0) : ($urandom % 60 == 0);
        stop_all = ($urandom % 500 == 0);
        in_valid = ($urandom % 4 != 0);
        in_addr  = ($urandom % 25 == 0) ? ADDR_W'($urandom) : ADDR_W'(m_count);
        if ($urandom % 30 == 0) in_data = 8'($urandom);
        else if ($urandom % 6 == 0) in_data = 8'h20;
        else in_data = 8'(8'h61 + $urandom_range(0, 25));
      end
    end

    idle(); idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
